// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the pipeline.
// Plain ALU results are registered straight through to the MEM/WB register
// with one cycle of latency. Loads and stores stall the upstream stages and
// hold a request on the data-memory port until the memory acknowledges it.
// Optional feature macro: MEM_TIMEOUT_EN. When defined, an access that sees
// no acknowledge is aborted after a bounded wait and reported on
// o_mem_err_out. When undefined, BUSY waits indefinitely and o_mem_err_out
// is tied low.
module mem_access_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  // Upstream (EX/MEM) inputs
  input  logic        i_valid_in,
  input  logic        i_mem_read_in,
  input  logic        i_mem_write_in,
  input  logic        i_reg_write_in,
  input  logic        i_ret_future_in,
  input  logic [3:0]  i_reg_rd_in,
  input  logic [15:0] i_alu_result_in,
  input  logic [15:0] i_store_data_in,
  // Data-memory port
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [15:0] o_dmem_addr,
  output logic [15:0] o_dmem_wdata,
  input  logic [15:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  // Downstream (MEM/WB) outputs
  output logic        o_valid_out,
  output logic        o_reg_write_out,
  output logic        o_ret_future_out,
  output logic [3:0]  o_reg_rd_out,
  output logic [15:0] o_alu_result_out,
  output logic [15:0] o_mem_read_data_out,
  output logic        o_mem_err_out,
  // Hazard output to freeze the upstream stages
  output logic        o_stall_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Decoded events for the current cycle
  logic w_memOp;
  logic w_pass;
  logic w_accept;
  logic w_complete;
  logic w_timeout;
  logic w_stall;

  // Control fields captured when a memory access is accepted; they are
  // released to the MEM/WB outputs only when the access finishes.
  logic       r_latRead;
  logic       r_latWrite;
  logic       r_latRegWrite;
  logic       r_latRetFuture;
  logic [3:0] r_latRd;

  // Registered outputs
  logic        r_valid;
  logic        r_regWrite;
  logic        r_retFuture;
  logic [3:0]  r_rd;
  logic [15:0] r_alu;
  logic [15:0] r_rdata;
  logic        r_dmemReq;
  logic        r_dmemWe;
  logic [15:0] r_dmemAddr;
  logic [15:0] r_dmemWdata;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_count;
  logic       r_err;
`endif

  // State register: the only place the FSM state changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: enter BUSY on an accepted memory op and leave it on
  // acknowledge or, when enabled, on timeout.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_complete || w_timeout) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output/decode logic: classify the cycle and raise the stall. The stall
  // drops in the cycle the access finishes so upstream can advance; a new
  // op presented in that cycle is therefore only taken from IDLE next cycle.
  always_comb begin
    w_memOp    = i_mem_read_in | i_mem_write_in;
    w_pass     = (r_state == IDLE) && i_valid_in && !w_memOp;
    w_accept   = (r_state == IDLE) && i_valid_in && w_memOp;
    w_complete = (r_state == BUSY) && i_dmem_ack;
`ifdef MEM_TIMEOUT_EN
    // Ack in the same cycle wins over the timeout.
    w_timeout  = (r_state == BUSY) && !i_dmem_ack && (r_count == 8'd254);
`else
    w_timeout  = 1'b0;
`endif
    w_stall    = w_accept || ((r_state == BUSY) && !i_dmem_ack && !w_timeout);
  end

  // Capture the control fields of an accepted memory op.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_latRead      <= 1'b0;
      r_latWrite     <= 1'b0;
      r_latRegWrite  <= 1'b0;
      r_latRetFuture <= 1'b0;
      r_latRd        <= 4'd0;
    end else if (w_accept) begin
      r_latRead      <= i_mem_read_in;
      r_latWrite     <= i_mem_write_in;
      r_latRegWrite  <= i_reg_write_in;
      r_latRetFuture <= i_ret_future_in;
      r_latRd        <= i_reg_rd_in;
    end
  end

  // Drive the data-memory port: request, address and data are registered on
  // acceptance and held untouched until the access finishes or is aborted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dmemReq   <= 1'b0;
      r_dmemWe    <= 1'b0;
      r_dmemAddr  <= 16'd0;
      r_dmemWdata <= 16'd0;
    end else if (w_accept) begin
      r_dmemReq   <= 1'b1;
      r_dmemWe    <= i_mem_write_in;
      r_dmemAddr  <= i_alu_result_in;
      r_dmemWdata <= i_store_data_in;
    end else if (w_complete || w_timeout) begin
      r_dmemReq   <= 1'b0;
      r_dmemWe    <= 1'b0;
    end
  end

  // Produce the MEM/WB outputs. valid_out defaults low so every instruction
  // gives exactly one single-cycle pulse; the payload holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_retFuture <= 1'b0;
      r_rd        <= 4'd0;
      r_alu       <= 16'd0;
      r_rdata     <= 16'd0;
    end else begin
      r_valid <= 1'b0;
      if (w_pass) begin
        r_valid     <= 1'b1;
        r_regWrite  <= i_reg_write_in;
        r_retFuture <= i_ret_future_in;
        r_rd        <= i_reg_rd_in;
        r_alu       <= i_alu_result_in;
        r_rdata     <= 16'd0;
      end else if (w_complete) begin
        r_valid     <= 1'b1;
        r_regWrite  <= r_latRegWrite;
        r_retFuture <= r_latRetFuture;
        r_rd        <= r_latRd;
        r_alu       <= r_dmemAddr;
        // A write (including read+write) returns no load data.
        r_rdata     <= (r_latRead && !r_latWrite) ? i_dmem_rdata : 16'd0;
      end else if (w_timeout) begin
        // Aborted access: deliver the slot but suppress the register write.
        r_valid     <= 1'b1;
        r_regWrite  <= 1'b0;
        r_retFuture <= r_latRetFuture;
        r_rd        <= r_latRd;
        r_alu       <= r_dmemAddr;
        r_rdata     <= 16'd0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Count BUSY cycles without acknowledge; restarts on every new access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (w_accept) begin
      r_count <= 8'd0;
    end else if ((r_state == BUSY) && !i_dmem_ack) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Error flag pulses alongside valid_out for the aborted access only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign o_mem_err_out = r_err;
`else
  assign o_mem_err_out = 1'b0;
`endif

  assign o_stall_out         = w_stall;
  assign o_valid_out         = r_valid;
  assign o_reg_write_out     = r_regWrite;
  assign o_ret_future_out    = r_retFuture;
  assign o_reg_rd_out        = r_rd;
  assign o_alu_result_out    = r_alu;
  assign o_mem_read_data_out = r_rdata;
  assign o_dmem_req          = r_dmemReq;
  assign o_dmem_we           = r_dmemWe;
  assign o_dmem_addr         = r_dmemAddr;
  assign o_dmem_wdata        = r_dmemWdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed steps with a scoreboard of expected
// MEM/WB results, popped whenever the DUT pulses valid_out.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validIn = 1'b0;
  logic        memReadIn = 1'b0;
  logic        memWriteIn = 1'b0;
  logic        regWriteIn = 1'b0;
  logic        retFutureIn = 1'b0;
  logic [3:0]  regRdIn = 4'd0;
  logic [15:0] aluResultIn = 16'd0;
  logic [15:0] storeDataIn = 16'd0;
  logic [15:0] dmemRdata = 16'd0;
  logic        dmemAck = 1'b0;

  logic        dmemReq;
  logic        dmemWe;
  logic [15:0] dmemAddr;
  logic [15:0] dmemWdata;
  logic        validOut;
  logic        regWriteOut;
  logic        retFutureOut;
  logic [3:0]  regRdOut;
  logic [15:0] aluResultOut;
  logic [15:0] memReadDataOut;
  logic        memErrOut;
  logic        stallOut;

  typedef struct packed {
    logic        regWrite;
    logic        retFuture;
    logic [3:0]  rd;
    logic [15:0] alu;
    logic [15:0] rdata;
    logic        err;
  } expOut_t;

  expOut_t sbQueue[$];
  int vectors = 0;
  int errors  = 0;

  mem_access_unit dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_valid_in          (validIn),
    .i_mem_read_in       (memReadIn),
    .i_mem_write_in      (memWriteIn),
    .i_reg_write_in      (regWriteIn),
    .i_ret_future_in     (retFutureIn),
    .i_reg_rd_in         (regRdIn),
    .i_alu_result_in     (aluResultIn),
    .i_store_data_in     (storeDataIn),
    .o_dmem_req          (dmemReq),
    .o_dmem_we           (dmemWe),
    .o_dmem_addr         (dmemAddr),
    .o_dmem_wdata        (dmemWdata),
    .i_dmem_rdata        (dmemRdata),
    .i_dmem_ack          (dmemAck),
    .o_valid_out         (validOut),
    .o_reg_write_out     (regWriteOut),
    .o_ret_future_out    (retFutureOut),
    .o_reg_rd_out        (regRdOut),
    .o_alu_result_out    (aluResultOut),
    .o_mem_read_data_out (memReadDataOut),
    .o_mem_err_out       (memErrOut),
    .o_stall_out         (stallOut)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one upstream instruction slot.
  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic rw, input logic rf, input logic [3:0] dst,
                               input logic [15:0] alu, input logic [15:0] sd);
    validIn     = v;
    memReadIn   = rd;
    memWriteIn  = wr;
    regWriteIn  = rw;
    retFutureIn = rf;
    regRdIn     = dst;
    aluResultIn = alu;
    storeDataIn = sd;
  endtask

  task automatic pushExpect(input logic rw, input logic rf, input logic [3:0] dst,
                            input logic [15:0] alu, input logic [15:0] rdata,
                            input logic err);
    expOut_t e;
    e.regWrite  = rw;
    e.retFuture = rf;
    e.rd        = dst;
    e.alu       = alu;
    e.rdata     = rdata;
    e.err       = err;
    sbQueue.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, and retire any
  // valid_out pulse against the scoreboard.
  task automatic tick();
    expOut_t e;
    @(posedge clk);
    #1;
    if (validOut === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spurious_valid", {15'd0, validOut}, 16'h0000);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("sb_reg_write",  {15'd0, regWriteOut},  {15'd0, e.regWrite});
        checkOutput("sb_ret_future", {15'd0, retFutureOut}, {15'd0, e.retFuture});
        checkOutput("sb_rd",         {12'd0, regRdOut},     {12'd0, e.rd});
        checkOutput("sb_alu",        aluResultOut,          e.alu);
        checkOutput("sb_rdata",      memReadDataOut,        e.rdata);
        checkOutput("sb_err",        {15'd0, memErrOut},    {15'd0, e.err});
      end
    end
  endtask

  initial begin
    int stallCycles;
    int pulseAt;
    $display("[TB] start");

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    tick();
    tick();
    checkOutput("rst_valid",     {15'd0, validOut},     16'h0);
    checkOutput("rst_reg_write", {15'd0, regWriteOut},  16'h0);
    checkOutput("rst_ret",       {15'd0, retFutureOut}, 16'h0);
    checkOutput("rst_rd",        {12'd0, regRdOut},     16'h0);
    checkOutput("rst_alu",       aluResultOut,          16'h0);
    checkOutput("rst_rdata",     memReadDataOut,        16'h0);
    checkOutput("rst_err",       {15'd0, memErrOut},    16'h0);
    checkOutput("rst_req",       {15'd0, dmemReq},      16'h0);
    checkOutput("rst_we",        {15'd0, dmemWe},       16'h0);
    checkOutput("rst_addr",      dmemAddr,              16'h0);
    checkOutput("rst_wdata",     dmemWdata,             16'h0);
    rst = 1'b0;

    // ALU pass-through, one-cycle latency, no stall
    applyStimulus(1, 0, 0, 1, 0, 4'd5, 16'h1234, 16'h0);
    #1;
    checkOutput("alu_stall", {15'd0, stallOut}, 16'h0);
    pushExpect(1, 0, 4'd5, 16'h1234, 16'h0, 0);
    tick();
    checkOutput("alu_valid", {15'd0, validOut}, 16'h1);

    // Idle slot with a stray ack: bubble, payload holds, ack ignored
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h9999, 16'h0);
    dmemAck = 1'b1;
    #1;
    checkOutput("idle_stall", {15'd0, stallOut}, 16'h0);
    tick();
    checkOutput("idle_valid", {15'd0, validOut}, 16'h0);
    checkOutput("idle_alu_hold", aluResultOut, 16'h1234);
    checkOutput("idle_rd_hold", {12'd0, regRdOut}, 16'h5);
    checkOutput("idle_ack_req", {15'd0, dmemReq}, 16'h0);
    dmemAck = 1'b0;

    // Load at 0x0040, ack in the fourth BUSY cycle with 0xBEEF
    applyStimulus(1, 1, 0, 1, 0, 4'd3, 16'h0040, 16'h0);
    #1;
    checkOutput("ld_stall_accept", {15'd0, stallOut}, 16'h1);
    pushExpect(1, 0, 4'd3, 16'h0040, 16'hBEEF, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("ld_stall_busy", {15'd0, stallOut}, 16'h1);
      checkOutput("ld_req", {15'd0, dmemReq}, 16'h1);
      checkOutput("ld_addr", dmemAddr, 16'h0040);
      checkOutput("ld_we", {15'd0, dmemWe}, 16'h0);
      checkOutput("ld_bubble", {15'd0, validOut}, 16'h0);
      tick();
    end
    dmemAck   = 1'b1;
    dmemRdata = 16'hBEEF;
    #1;
    checkOutput("ld_stall_ack", {15'd0, stallOut}, 16'h0);
    checkOutput("ld_addr_ack", dmemAddr, 16'h0040);
    tick();
    checkOutput("ld_valid", {15'd0, validOut}, 16'h1);
    checkOutput("ld_req_done", {15'd0, dmemReq}, 16'h0);
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;
    tick();
    checkOutput("ld_single_pulse", {15'd0, validOut}, 16'h0);

    // Store 0x00FF to 0x0080, ack in first BUSY cycle
    applyStimulus(1, 0, 1, 0, 0, 4'd7, 16'h0080, 16'h00FF);
    #1;
    checkOutput("st_stall_accept", {15'd0, stallOut}, 16'h1);
    pushExpect(0, 0, 4'd7, 16'h0080, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    checkOutput("st_req", {15'd0, dmemReq}, 16'h1);
    checkOutput("st_we", {15'd0, dmemWe}, 16'h1);
    checkOutput("st_addr", dmemAddr, 16'h0080);
    checkOutput("st_wdata", dmemWdata, 16'h00FF);
    dmemAck   = 1'b1;
    dmemRdata = 16'hABCD;
    #1;
    checkOutput("st_stall_ack", {15'd0, stallOut}, 16'h0);
    tick();
    checkOutput("st_valid", {15'd0, validOut}, 16'h1);
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;

    // Read and write together: write only, no load data returned
    applyStimulus(1, 1, 1, 1, 1, 4'd9, 16'h00C0, 16'h1357);
    pushExpect(1, 1, 4'd9, 16'h00C0, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    checkOutput("rw_we", {15'd0, dmemWe}, 16'h1);
    checkOutput("rw_wdata", dmemWdata, 16'h1357);
    dmemAck   = 1'b1;
    dmemRdata = 16'h5555;
    tick();
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;

    // Reset in the second BUSY cycle aborts the load; later ack ignored
    applyStimulus(1, 1, 0, 1, 0, 4'd4, 16'h0300, 16'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_req", {15'd0, dmemReq}, 16'h0);
    checkOutput("abort_valid", {15'd0, validOut}, 16'h0);
    checkOutput("abort_alu", aluResultOut, 16'h0);
    checkOutput("abort_rd", {12'd0, regRdOut}, 16'h0);
    checkOutput("abort_addr", dmemAddr, 16'h0);
    rst       = 1'b0;
    dmemAck   = 1'b1;
    dmemRdata = 16'hDEAD;
    tick();
    checkOutput("late_ack_valid", {15'd0, validOut}, 16'h0);
    checkOutput("late_ack_req", {15'd0, dmemReq}, 16'h0);
    checkOutput("late_ack_rdata", memReadDataOut, 16'h0);
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;
    tick();

    // Back-to-back loads: second one presented during the ack cycle
    applyStimulus(1, 1, 0, 1, 0, 4'd1, 16'h0100, 16'h0);
    pushExpect(1, 0, 4'd1, 16'h0100, 16'h0001, 0);
    tick();
    applyStimulus(1, 1, 0, 1, 0, 4'd2, 16'h0200, 16'h0);
    dmemAck   = 1'b1;
    dmemRdata = 16'h0001;
    #1;
    checkOutput("b2b_stall_ack", {15'd0, stallOut}, 16'h0);
    tick();
    checkOutput("b2b_first_valid", {15'd0, validOut}, 16'h1);
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;
    #1;
    checkOutput("b2b_restall", {15'd0, stallOut}, 16'h1);
    pushExpect(1, 0, 4'd2, 16'h0200, 16'h0002, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    checkOutput("b2b_addr2", dmemAddr, 16'h0200);
    checkOutput("b2b_bubble", {15'd0, validOut}, 16'h0);
    dmemAck   = 1'b1;
    dmemRdata = 16'h0002;
    tick();
    checkOutput("b2b_second_valid", {15'd0, validOut}, 16'h1);
    dmemAck   = 1'b0;
    dmemRdata = 16'h0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Load never acked: aborted with an error pulse after 255 BUSY cycles
    applyStimulus(1, 1, 0, 1, 0, 4'd6, 16'h0400, 16'h0);
    pushExpect(0, 0, 4'd6, 16'h0400, 16'h0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    pulseAt = 0;
    for (int i = 0; i < 300 && pulseAt == 0; i++) begin
      tick();
      if (validOut === 1'b1) pulseAt = i + 1;
    end
    checkOutput("timeout_cycles", pulseAt[15:0], 16'd255);
    checkOutput("timeout_req", {15'd0, dmemReq}, 16'h0);
    tick();
    checkOutput("timeout_err_pulse", {15'd0, memErrOut}, 16'h0);
`else
    // Load never acked: stall holds indefinitely
    applyStimulus(1, 1, 0, 1, 0, 4'd6, 16'h0400, 16'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    stallCycles = 0;
    pulseAt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (stallOut === 1'b1 && validOut === 1'b0) stallCycles++;
      tick();
    end
    checkOutput("hang_stall_cycles", stallCycles[15:0], 16'd1000);
    checkOutput("hang_err", {15'd0, memErrOut}, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    checkOutput("sb_drained", sbQueue.size() > 0 ? 16'h1 : 16'h0, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
